fir_coeff_loader: RTL and testbench

- Writer side of the FIR coefficient array. Accepts a coefficient frame over a valid/ready stream into a shadow bank.
- On a complete, well-formed frame, copies the shadow bank atomically into the active bank. The active bank drives the FIR coeff[1:TAPS] input directly.
- The swap is gated by swap_en, so the filter never sees a half-updated coefficient set mid-sample.

---
 rtl/fir_pkg.sv | 20 ++
 rtl/fir_coeff_loader.sv | 161 ++++++++++++++++
 tb/tb_fir_coeff_loader.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared FIR definitions: default coefficient width and tap count (also used
// by the FIR_transposed instances), the coefficient type, and the loader
// state enumeration.
// ---------------------------------------------------------------------------
package fir_pkg;

   localparam int unsigned FIR_DATA_WIDTH = 16;
   localparam int unsigned FIR_TAPS       = 53;

   typedef logic signed [FIR_DATA_WIDTH-1:0] coeff_t;

   typedef enum logic [1:0] {
      LD_LOAD    = 2'd0,
      LD_PENDING = 2'd1,
      LD_DRAIN   = 2'd2
   } loader_state_t;

endpackage : fir_pkg

// File: rtl/fir_coeff_loader.sv
// ---------------------------------------------------------------------------
// fir_coeff_loader
// Writer side of the FIR coefficient array. A coefficient frame arrives on a
// valid/ready stream into a shadow bank; a complete frame of exactly TAPS
// words is copied atomically into the active bank on the next swap_en strobe,
// so the filter never sees a half-updated coefficient set.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   s_tdata      signed coefficient word
//   s_tvalid     word valid
//   s_tready     loader can accept a word (decoded from state)
//   s_tlast      last word of the frame
//   swap_en      safe-to-swap strobe (e.g. sample boundary)
//   coeff        active coefficient bank [1:TAPS] to the FIR
//   coeff_valid  at least one frame committed since reset
//   swap_done    one-cycle pulse in the cycle the active bank changes
//   frame_err    one-cycle pulse on a frame length error
//   busy         frame partially received or swap pending (decoded)
// ---------------------------------------------------------------------------
module fir_coeff_loader
   import fir_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FIR_DATA_WIDTH,
   parameter int unsigned TAPS       = FIR_TAPS
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic signed [DATA_WIDTH-1:0] s_tdata,
   input  logic                         s_tvalid,
   output logic                         s_tready,
   input  logic                         s_tlast,
   input  logic                         swap_en,
   output logic signed [DATA_WIDTH-1:0] coeff [1:TAPS],
   output logic                         coeff_valid,
   output logic                         swap_done,
   output logic                         frame_err,
   output logic                         busy
);

   localparam int unsigned IDX_W = $clog2(TAPS + 1);
   localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(TAPS);

   loader_state_t          state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic                   rdy_en_q, rdy_en_d;
   logic                   coeff_valid_q, coeff_valid_d;
   logic                   swap_done_q, swap_done_d;
   logic                   frame_err_q, frame_err_d;
   logic                   shadow_we_c;
   logic                   commit_c;
   logic                   accept_c;

   logic signed [DATA_WIDTH-1:0] shadow_q [1:TAPS];
   logic signed [DATA_WIDTH-1:0] active_q [1:TAPS];

   // rdy_en_q holds s_tready low until the first edge after reset release.
   assign s_tready = rdy_en_q & (state_q != LD_PENDING);
   assign busy     = (state_q != LD_LOAD) | (idx_q != IDX_FIRST);
   assign accept_c = s_tvalid & s_tready;

   assign coeff       = active_q;
   assign coeff_valid = coeff_valid_q;
   assign swap_done   = swap_done_q;
   assign frame_err   = frame_err_q;

   // State and control registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= LD_LOAD;
         idx_q         <= IDX_FIRST;
         rdy_en_q      <= 1'b0;
         coeff_valid_q <= 1'b0;
         swap_done_q   <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         rdy_en_q      <= rdy_en_d;
         coeff_valid_q <= coeff_valid_d;
         swap_done_q   <= swap_done_d;
         frame_err_q   <= frame_err_d;
      end
   end

   // Next-state and bank-control decode.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      rdy_en_d      = 1'b1;
      coeff_valid_d = coeff_valid_q;
      swap_done_d   = 1'b0;
      frame_err_d   = 1'b0;
      shadow_we_c   = 1'b0;
      commit_c      = 1'b0;

      case (state_q)
         LD_LOAD: begin
            if (accept_c) begin
               if (idx_q == IDX_LAST) begin
                  if (s_tlast) begin
                     shadow_we_c = 1'b1;
                     state_d     = LD_PENDING;
                  end else begin
                     // Too many words: flag once, then swallow the rest.
                     frame_err_d = 1'b1;
                     state_d     = LD_DRAIN;
                  end
               end else if (s_tlast) begin
                  // Short frame: drop it and restart at word 1.
                  frame_err_d = 1'b1;
                  idx_d       = IDX_FIRST;
               end else begin
                  shadow_we_c = 1'b1;
                  idx_d       = idx_q + IDX_W'(1);
               end
            end
         end

         LD_PENDING: begin
            if (swap_en) begin
               commit_c      = 1'b1;
               coeff_valid_d = 1'b1;
               swap_done_d   = 1'b1;
               idx_d         = IDX_FIRST;
               state_d       = LD_LOAD;
            end
         end

         LD_DRAIN: begin
            if (accept_c && s_tlast) begin
               idx_d   = IDX_FIRST;
               state_d = LD_LOAD;
            end
         end

         default: begin
            idx_d   = IDX_FIRST;
            state_d = LD_LOAD;
         end
      endcase
   end

   // Shadow bank capture and atomic shadow-to-active copy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_q <= '{default: '0};
         active_q <= '{default: '0};
      end else begin
         if (shadow_we_c) begin
            shadow_q[idx_q] <= s_tdata;
         end
         if (commit_c) begin
            active_q <= shadow_q;
         end
      end
   end

endmodule : fir_coeff_loader

// File: tb/tb_fir_coeff_loader.sv
// ---------------------------------------------------------------------------
// tb_fir_coeff_loader
// Self-checking bench for fir_coeff_loader with TAPS=4, DATA_WIDTH=16.
// A frame-level reference model (word queue plus pending/drain flags) predicts
// every output on every clock.
// ---------------------------------------------------------------------------
module tb_fir_coeff_loader;

   localparam int DW = 16;
   localparam int NT = 4;

   logic                 clk = 1'b0;
   logic                 reset;
   logic signed [DW-1:0] s_tdata;
   logic                 s_tvalid;
   logic                 s_tready;
   logic                 s_tlast;
   logic                 swap_en;
   logic signed [DW-1:0] coeff [1:NT];
   logic                 coeff_valid;
   logic                 swap_done;
   logic                 frame_err;
   logic                 busy;

   always #5 clk = ~clk;

   fir_coeff_loader #(
      .DATA_WIDTH (DW),
      .TAPS       (NT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .s_tdata     (s_tdata),
      .s_tvalid    (s_tvalid),
      .s_tready    (s_tready),
      .s_tlast     (s_tlast),
      .swap_en     (swap_en),
      .coeff       (coeff),
      .coeff_valid (coeff_valid),
      .swap_done   (swap_done),
      .frame_err   (frame_err),
      .busy        (busy)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model: words of the frame in flight, and what happens next.
   bit          m_started;
   bit          m_pending;
   bit          m_drain;
   bit          m_valid;
   bit          m_swap;
   bit          m_err;
   logic [15:0] m_act [1:NT];
   logic [15:0] m_frame [$];
   bit          last_acc;

   task automatic model_reset();
      m_started = 1'b0;
      m_pending = 1'b0;
      m_drain   = 1'b0;
      m_valid   = 1'b0;
      m_swap    = 1'b0;
      m_err     = 1'b0;
      for (int i = 1; i <= NT; i++) m_act[i] = '0;
      m_frame.delete();
   endtask

   task automatic check_decoded();
      chk("s_tready", {31'b0, s_tready}, {31'b0, m_started && !m_pending});
      chk("busy", {31'b0, busy}, {31'b0, m_pending || m_drain || (m_frame.size() != 0)});
   endtask

   task automatic check_regs();
      chk("coeff_valid", {31'b0, coeff_valid}, {31'b0, m_valid});
      chk("swap_done", {31'b0, swap_done}, {31'b0, m_swap});
      chk("frame_err", {31'b0, frame_err}, {31'b0, m_err});
      for (int i = 1; i <= NT; i++)
         chk($sformatf("coeff[%0d]", i), {16'b0, coeff[i]}, {16'b0, m_act[i]});
   endtask

   // One clock: check decoded outputs, advance the model, then check registers.
   task automatic step();
      bit acc;
      check_decoded();
      acc    = m_started && !m_pending && s_tvalid;
      m_swap = 1'b0;
      m_err  = 1'b0;
      if (!m_started) begin
         m_started = 1'b1;
      end else if (m_pending) begin
         if (swap_en) begin
            for (int i = 1; i <= NT; i++) m_act[i] = m_frame[i-1];
            m_valid   = 1'b1;
            m_swap    = 1'b1;
            m_pending = 1'b0;
            m_frame.delete();
         end
      end else if (acc) begin
         if (m_drain) begin
            if (s_tlast) m_drain = 1'b0;
         end else begin
            m_frame.push_back(s_tdata);
            if (s_tlast) begin
               if (m_frame.size() == NT) begin
                  m_pending = 1'b1;
               end else begin
                  m_err = 1'b1;
                  m_frame.delete();
               end
            end else if (m_frame.size() == NT) begin
               m_err   = 1'b1;
               m_drain = 1'b1;
               m_frame.delete();
            end
         end
      end
      last_acc = acc;
      @(posedge clk);
      #1;
      check_regs();
   endtask

   // Offer one word, with optional random valid gaps, until it is accepted.
   task automatic xfer(input logic [15:0] d, input bit last, input int gap_pct);
      int n;
      n       = 0;
      s_tdata = d;
      s_tlast = last;
      do begin
         s_tvalid = ($urandom_range(99) >= gap_pct);
         step();
         n++;
      end while (!last_acc && n < 64);
      chk("xfer_accepted", {31'b0, last_acc}, 32'd1);
      s_tvalid = 1'b0;
   endtask

   task automatic idle(input int n, input bit sw);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      swap_en  = sw;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic frame4(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d, input int gap_pct);
      xfer(a, 1'b0, gap_pct);
      xfer(b, 1'b0, gap_pct);
      xfer(c, 1'b0, gap_pct);
      xfer(d, 1'b1, gap_pct);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors so far", n_vec);
      $fatal(1);
   end

   initial begin
      reset    = 1'b1;
      s_tdata  = '0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      swap_en  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_decoded();
      check_regs();
      reset = 1'b0;

      // Good frame 1..4, swap strobe three cycles after the last word.
      idle(1, 1'b0);
      frame4(16'h0001, 16'h0002, 16'h0003, 16'h0004, 0);
      idle(2, 1'b0);
      idle(1, 1'b1);
      idle(2, 1'b0);

      // Short frame, then a good frame 5..8 with swap.
      xfer(16'h7FFF, 1'b0, 0);
      xfer(16'h8000, 1'b1, 0);
      idle(2, 1'b0);
      frame4(16'h0005, 16'h0006, 16'h0007, 16'h0008, 0);
      idle(1, 1'b1);
      idle(1, 1'b0);

      // Long frame of six words: error on the fourth, rest drained.
      for (int i = 1; i <= 6; i++) xfer(16'(16'h1100 + i), (i == 6), 0);
      idle(1, 1'b1);
      idle(2, 1'b0);

      // Random valid gaps with swap_en held high.
      swap_en = 1'b1;
      frame4(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 50);
      idle(3, 1'b1);
      swap_en = 1'b0;

      // swap_en during LOAD with two words in has no effect.
      swap_en = 1'b0;
      xfer(16'hA001, 1'b0, 0);
      xfer(16'hA002, 1'b0, 0);
      idle(2, 1'b1);
      swap_en = 1'b0;
      xfer(16'hA003, 1'b0, 0);
      xfer(16'hA004, 1'b1, 0);
      idle(1, 1'b0);
      idle(1, 1'b1);
      idle(1, 1'b0);

      // Async reset while a new frame is pending.
      frame4(16'hBEEF, 16'h1234, 16'hFFFF, 16'h8001, 0);
      idle(1, 1'b0);
      reset = 1'b1;
      #2;
      model_reset();
      check_decoded();
      check_regs();
      reset = 1'b0;
      idle(1, 1'b0);
      frame4(16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00, 25);
      idle(1, 1'b1);
      idle(1, 1'b0);

      // Random soak: mixed lengths, gaps and swap strobes.
      for (int i = 0; i < 300; i++) begin
         s_tdata  = 16'($urandom);
         s_tvalid = $urandom_range(1);
         s_tlast  = ($urandom_range(3) == 0);
         swap_en  = ($urandom_range(2) == 0);
         step();
      end
      idle(2, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_fir_coeff_loader
